// File: rtl/cell_pos_pingpong.sv
// cell_pos_pingpong: double-buffered per-cell particle position memory.
// The active bank serves force-evaluation reads through a 2-cycle read pipe.
// The shadow bank is filled by indexed writes and appends from motion update.
// A swap exchanges the two banks once all in-flight reads have drained.
// Particle counts are held in registers; word 0 of each bank is never used.
module cell_pos_pingpong #(
    parameter int COORD_WIDTH  = 32,
    parameter int DATA_WIDTH   = 3 * COORD_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  app_en,
    input  logic [DATA_WIDTH-1:0] app_data,
    output logic                  wr_ready,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic [ADDR_WIDTH-1:0] active_count,
    output logic [ADDR_WIDTH-1:0] shadow_count,
    output logic                  overflow,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(PARTICLE_NUM);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLIP
    } state_t;

    logic [DATA_WIDTH-1:0] bank0 [0:PARTICLE_NUM];
    logic [DATA_WIDTH-1:0] bank1 [0:PARTICLE_NUM];

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] active_count_q, active_count_d;
    logic [ADDR_WIDTH-1:0] shadow_count_q, shadow_count_d;
    logic                  overflow_q, overflow_d;
    logic                  addr_err_q, addr_err_d;
    logic                  swap_done_q, swap_done_d;

    logic                  rd_p1_valid_q, rd_p1_valid_d;
    logic [ADDR_WIDTH-1:0] rd_p1_addr_q, rd_p1_addr_d;
    logic                  rd_p2_valid_q, rd_p2_valid_d;
    logic [DATA_WIDTH-1:0] rd_p2_data_q, rd_p2_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  rd_accept;
    logic                  wr_addr_ok;
    logic                  wr_accept;
    logic                  wr_reject;
    logic                  app_accept;
    logic                  app_reject;
    logic [ADDR_WIDTH-1:0] app_addr;

    // Reads are refused from the moment a swap is requested until the swap
    // completes; in the swap_done cycle the port reopens even if swap_req is
    // still held, and a read accepted then is simply drained by the next swap.
    assign rd_ready   = (state_q == IDLE) && (!swap_req || swap_done_q);
    assign wr_ready   = (state_q != FLIP);
    assign rd_accept  = rd_en && rd_ready;
    assign wr_addr_ok = (wr_addr != '0) && (wr_addr <= MAX_ADDR);
    assign wr_accept  = wr_en && wr_ready && wr_addr_ok;
    assign wr_reject  = wr_en && wr_ready && !wr_addr_ok;
    assign app_accept = app_en && wr_ready && (shadow_count_q < MAX_ADDR);
    assign app_reject = app_en && wr_ready && (shadow_count_q >= MAX_ADDR);
    assign app_addr   = shadow_count_q + ADDR_WIDTH'(1);

    // Read pipe: register the address, then look up the active bank, then
    // present the result, giving two cycles from accept to rd_valid.
    always_comb begin
        rd_p1_valid_d = rd_accept;
        rd_p1_addr_d  = rd_addr;
        rd_p2_valid_d = rd_p1_valid_q;
        rd_p2_data_d  = '0;
        if (rd_p1_valid_q) begin
            if (rd_p1_addr_q == '0) begin
                rd_p2_data_d = DATA_WIDTH'(active_count_q);
            end else if (rd_p1_addr_q <= active_count_q) begin
                rd_p2_data_d = sel_q ? bank1[rd_p1_addr_q] : bank0[rd_p1_addr_q];
            end
        end
        rd_valid_d = rd_p2_valid_q;
        rd_data_d  = rd_p2_data_q;
    end

    // Swap control, shadow count bookkeeping and sticky error flags.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        active_count_d = active_count_q;
        shadow_count_d = app_accept ? app_addr : shadow_count_q;
        overflow_d     = overflow_q || app_reject;
        addr_err_d     = addr_err_q || wr_reject;
        swap_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_p1_valid_q && !rd_p2_valid_q) begin
                    state_d = FLIP;
                end
            end
            FLIP: begin
                sel_d          = ~sel_q;
                active_count_d = shadow_count_q;
                shadow_count_d = '0;
                swap_done_d    = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and read-pipe registers, all cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sel_q          <= 1'b0;
            active_count_q <= '0;
            shadow_count_q <= '0;
            overflow_q     <= 1'b0;
            addr_err_q     <= 1'b0;
            swap_done_q    <= 1'b0;
            rd_p1_valid_q  <= 1'b0;
            rd_p1_addr_q   <= '0;
            rd_p2_valid_q  <= 1'b0;
            rd_p2_data_q   <= '0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            active_count_q <= active_count_d;
            shadow_count_q <= shadow_count_d;
            overflow_q     <= overflow_d;
            addr_err_q     <= addr_err_d;
            swap_done_q    <= swap_done_d;
            rd_p1_valid_q  <= rd_p1_valid_d;
            rd_p1_addr_q   <= rd_p1_addr_d;
            rd_p2_valid_q  <= rd_p2_valid_d;
            rd_p2_data_q   <= rd_p2_data_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    // Shadow bank writes; the append is issued last so it wins an address tie.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            if (sel_q) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
        if (app_accept) begin
            if (sel_q) begin
                bank0[app_addr] <= app_data;
            end else begin
                bank1[app_addr] <= app_data;
            end
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign swap_done    = swap_done_q;
    assign active_count = active_count_q;
    assign shadow_count = shadow_count_q;
    assign overflow     = overflow_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_cell_pos_pingpong.sv
// Testbench for cell_pos_pingpong: a bank model predicts every read result,
// expected reads are queued with their due cycle and matched when rd_valid fires.
module tb_cell_pos_pingpong;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clock;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          app_en;
    logic [DW-1:0] app_data;
    logic          wr_ready;
    logic          swap_req;
    logic          swap_done;
    logic [AW-1:0] active_count;
    logic [AW-1:0] shadow_count;
    logic          overflow;
    logic          addr_err;

    cell_pos_pingpong #(
        .COORD_WIDTH (32),
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .app_en      (app_en),
        .app_data    (app_data),
        .wr_ready    (wr_ready),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .active_count(active_count),
        .shadow_count(shadow_count),
        .overflow    (overflow),
        .addr_err    (addr_err)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            assert_count = 0;
    int            fail_count   = 0;
    int            cycle_cnt    = 0;
    logic          monitor_on   = 1'b0;

    // Reference model of both banks, the counts and the sticky flags.
    logic [DW-1:0] m_bank [0:1][0:PN];
    logic          m_sel;
    int            m_acnt;
    int            m_scnt;
    logic          m_ovf;
    logic          m_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter used to check read latency.
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] mkWord(input int i);
        return {32'(i), 32'(i * 3 + 1), 32'(i * 7 + 2)};
    endfunction

    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
        if (a == 0) return DW'(m_acnt);
        if (int'(a) <= m_acnt) return m_bank[m_sel][a];
        return '0;
    endfunction

    // Scoreboard: match each valid read against the oldest expectation.
    always @(negedge clock) begin
        if (monitor_on) begin
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rd_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("rd_data", rd_data, e.data);
                    checkOutput("rd_latency", DW'(cycle_cnt), DW'(e.due));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cycle_cnt) begin
                checkOutput("rd_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of port activity, applied at a falling edge; the model is
    // updated as the DUT will be at the next rising edge.
    task automatic applyStimulus(input logic re, input logic [AW-1:0] ra,
                                 input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic ae,
                                 input logic [DW-1:0] ad);
        exp_t e;
        rd_en    = re;
        rd_addr  = ra;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        app_en   = ae;
        app_data = ad;
        if (re) begin
            e.data = modelRead(ra);
            e.due  = cycle_cnt + 3;
            exp_q.push_back(e);
        end
        if (we) begin
            if (wa != 0 && int'(wa) <= PN) m_bank[!m_sel][wa] = wd;
            else m_err = 1'b1;
        end
        if (ae) begin
            if (m_scnt < PN) begin
                m_scnt++;
                m_bank[!m_sel][m_scnt] = ad;
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(negedge clock);
    endtask

    task automatic doRead(input logic [AW-1:0] a);
        applyStimulus(1'b1, a, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic doAppend(input logic [DW-1:0] d);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, d);
    endtask

    task automatic doIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic doSwap(input string tag);
        int   start_cyc;
        int   flip_cycles;
        logic seen;
        logic rd_ready_bad;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        app_en       = 1'b0;
        swap_req     = 1'b1;
        start_cyc    = cycle_cnt;
        seen         = 1'b0;
        flip_cycles  = 0;
        rd_ready_bad = 1'b0;
        #1;
        checkOutput({tag, "_rd_ready_drop"}, rd_ready, 0);
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clock);
            if (wr_ready === 1'b0) flip_cycles++;
            if (swap_done === 1'b1) seen = 1'b1;
            else if (rd_ready !== 1'b0) rd_ready_bad = 1'b1;
        end
        checkOutput({tag, "_swap_done"}, seen, 1);
        checkOutput({tag, "_done_in_time"}, cycle_cnt <= start_cyc + 5, 1);
        checkOutput({tag, "_rd_ready_low"}, rd_ready_bad, 0);
        checkOutput({tag, "_rd_ready_back"}, rd_ready, 1);
        checkOutput({tag, "_flip_cycles"}, DW'(flip_cycles), 1);
        swap_req = 1'b0;
        m_sel  = !m_sel;
        m_acnt = m_scnt;
        m_scnt = 0;
        checkOutput({tag, "_active_count"}, DW'(active_count), DW'(m_acnt));
        checkOutput({tag, "_shadow_count"}, DW'(shadow_count), 0);
        @(negedge clock);
        checkOutput({tag, "_done_pulse"}, swap_done, 0);
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_overflow"}, overflow, m_ovf);
        checkOutput({tag, "_addr_err"}, addr_err, m_err);
        checkOutput({tag, "_active_count"}, DW'(active_count), DW'(m_acnt));
        checkOutput({tag, "_shadow_count"}, DW'(shadow_count), DW'(m_scnt));
    endtask

    task automatic modelReset();
        m_sel  = 1'b0;
        m_acnt = 0;
        m_scnt = 0;
        m_ovf  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_valid"}, rd_valid, 0);
        checkOutput({tag, "_rd_data"}, rd_data, 0);
        checkOutput({tag, "_swap_done"}, swap_done, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_addr_err"}, addr_err, 0);
        checkOutput({tag, "_active_count"}, DW'(active_count), 0);
        checkOutput({tag, "_shadow_count"}, DW'(shadow_count), 0);
        checkOutput({tag, "_rd_ready"}, rd_ready, 1);
        checkOutput({tag, "_wr_ready"}, wr_ready, 1);
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int w = 0; w <= PN; w++) m_bank[b][w] = '0;
        modelReset();
        rst_n    = 1'b1;
        rd_en    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        app_en   = 1'b0;
        app_data = '0;
        swap_req = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clock);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clock);
        monitor_on = 1'b1;

        $display("[TB] reads after reset");
        doRead(8'd0);
        doRead(8'd5);
        doIdle(4);
        checkFlags("post_reset");

        $display("[TB] append three words and swap");
        doAppend(mkWord(101));
        doAppend(mkWord(102));
        doAppend(mkWord(103));
        checkFlags("after_append3");
        doSwap("swap1");
        doRead(8'd1);
        doRead(8'd2);
        doRead(8'd3);
        doRead(8'd4);
        doRead(8'd0);
        doIdle(4);

        $display("[TB] reads in flight across a swap");
        doAppend(mkWord(201));
        doAppend(mkWord(202));
        doRead(8'd1);
        doRead(8'd2);
        doSwap("swap2");
        doRead(8'd1);
        doRead(8'd0);
        doIdle(4);

        $display("[TB] fill shadow bank to overflow");
        for (int i = 1; i <= PN; i++) doAppend(mkWord(1000 + i));
        checkFlags("full_no_ovf");
        doAppend(mkWord(5000));
        checkFlags("after_ovf");
        doSwap("swap3");
        doRead(8'd220);
        doRead(8'd1);
        doRead(8'd0);
        doRead(8'd221);
        doIdle(4);

        $display("[TB] write/append collision and bad write address");
        doAppend(mkWord(301));
        doAppend(mkWord(302));
        doAppend(mkWord(303));
        applyStimulus(1'b0, '0, 1'b1, 8'd4, mkWord(777), 1'b1, mkWord(304));
        applyStimulus(1'b0, '0, 1'b1, 8'd2, mkWord(888), 1'b0, '0);
        checkFlags("before_bad_wr");
        applyStimulus(1'b0, '0, 1'b1, 8'd0, mkWord(999), 1'b0, '0);
        checkFlags("after_bad_wr");
        doSwap("swap4");
        doRead(8'd4);
        doRead(8'd2);
        doRead(8'd1);
        doRead(8'd0);
        doIdle(4);

        $display("[TB] reset asserted during DRAIN");
        checkFlags("pre_drain_reset");
        swap_req = 1'b1;
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        swap_req = 1'b0;
        modelReset();
        #1;
        checkResetOutputs("drain_reset");
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        checkOutput("post_reset_rd_ready", rd_ready, 1);
        checkOutput("post_reset_active_count", DW'(active_count), 0);
        doRead(8'd0);
        doRead(8'd1);
        doIdle(4);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
        checkOutput("scoreboard_empty", DW'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cell_pos_pingpong.md
# cell_pos_pingpong

Parametrised, double-buffered cell position memory. It is the next generation of the single-bank per-cell position RAM. One bank (active) serves force-evaluation reads while the other (shadow) is filled by motion update through indexed writes or appends. A swap handshake exchanges the banks at the end of a timestep. It sits between the motion-update unit and the position cache of one cell, and keeps the per-cell particle count in hardware instead of in RAM word 0.

## Interface
- `COORD_WIDTH`, 32: width of one coordinate (single float).
- `DATA_WIDTH`, 3*COORD_WIDTH: position word, MSB-LSB {posz, posy, posx}.
- `PARTICLE_NUM`, 220: maximum particles per cell; legal particle addresses are 1..PARTICLE_NUM.
- `ADDR_WIDTH`, 8: address width; requires PARTICLE_NUM+1 <= 2^ADDR_WIDTH.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd_en` in 1: read request, accepted only when `rd_ready`=1.
- `rd_addr` in ADDR_WIDTH: 0 = particle count, i = particle i.
- `rd_ready` out 1: read port accepting.
- `rd_data` out DATA_WIDTH: read result from the active bank.
- `rd_valid` out 1: `rd_data` valid this cycle.
- `wr_en` in 1: indexed write to the shadow bank.
- `wr_addr` in ADDR_WIDTH: write target, 1..PARTICLE_NUM.
- `wr_data` in DATA_WIDTH: indexed write data.
- `app_en` in 1: append to the shadow bank at shadow_count+1.
- `app_data` in DATA_WIDTH: append data.
- `wr_ready` out 1: write/append port accepting.
- `swap_req` in 1: request a bank exchange; level, sampled in IDLE.
- `swap_done` out 1: one-cycle pulse when the exchange completes.
- `active_count` out ADDR_WIDTH: particle count of the active bank.
- `shadow_count` out ADDR_WIDTH: particle count of the shadow bank.
- `overflow` out 1: sticky; an append was dropped because the shadow bank was full.
- `addr_err` out 1: sticky; a write was dropped because its address was 0 or > PARTICLE_NUM.

## Operation
- Two storage banks, each PARTICLE_NUM+1 words. Word 0 is unused; counts live in registers.
- A `sel` register marks the active bank. After reset, `sel`=0 and bank 0 is active.
- **Reset values:** `rd_valid`=0, `rd_data`=0, `swap_done`=0, `overflow`=0, `addr_err`=0, both counts=0, `sel`=0, state IDLE, `rd_ready`=1, `wr_ready`=1. RAM contents are not reset.
- **Read:**
  - addr 0 returns the zero-extended `active_count`.
  - 1 <= addr <= `active_count` returns the stored word.
  - addr > `active_count` returns all zeros.
  - `rd_valid` is asserted for every accepted read, regardless of address.
- **Indexed write:** accepted if 1 <= `wr_addr` <= PARTICLE_NUM; otherwise dropped and `addr_err` set. Does not change `shadow_count`.
- **Append:**
  - If `shadow_count` < PARTICLE_NUM: writes at `shadow_count`+1 and increments `shadow_count`.
  - Otherwise: dropped and `overflow` set.
- **Same-cycle write and append:** both occur. If `wr_addr` equals the append target, the append data wins.
- **State machine:**
  - IDLE: `swap_req`=1 -> DRAIN; `rd_ready` drops in the same cycle.
  - DRAIN: stays until no reads are in flight (at most 2 cycles) -> FLIP.
  - FLIP: `wr_ready`=0 and writes/appends are ignored. At the edge, `sel` toggles, `active_count` <= old `shadow_count`, and the new shadow count <= 0. Then `swap_done`=1 for one cycle -> IDLE.
- A write or append presented while `wr_ready`=0 has no effect and sets no flag.
- Reset asserted mid-swap returns everything to reset values immediately.

## Timing
- Read latency is 2 cycles: an accept at edge N gives `rd_valid`/`rd_data` after edge N+2. Fully pipelined, one read per cycle.
- Writes and appends commit at the accepting edge. `shadow_count` updates on the same edge.
- Shadow writes never affect active reads. No read-during-write hazard exists.
- Swap sequence:
  - `swap_req` seen in IDLE at edge E.
  - Reads already accepted complete normally.
  - `swap_done` pulses no later than E+4.
  - `rd_ready` returns to 1 in the same cycle as `swap_done`.
- Reads accepted after `swap_done` return new-bank data.
- `swap_req` held high after `swap_done` starts another swap from IDLE.

## Test plan
- Reset, then read addr 0 -> `rd_valid` 2 cycles later, data 0. Read addr 5 -> 0. All flags 0.
- Append 3 words A, B, C; assert `swap_req` -> `swap_done` within 4 cycles, `active_count`=3, `shadow_count`=0. Reads of 1, 2, 3, 4, 0 -> A, B, C, 0, 3 on back-to-back cycles.
- Issue 2 reads, then `swap_req` one cycle later -> both reads return old-bank data, `rd_ready`=0 until `swap_done`, and the next read returns new-bank data.
- Make 221 appends -> `shadow_count`=220, `overflow`=1, word 220 holds the 220th append.
- Same cycle: `wr_addr`=4 with X, and append targeting 4 with Y -> after swap, addr 4 reads Y. Write to `wr_addr`=0 -> `addr_err`=1, counts unchanged.
- Deassert `rst_n` during DRAIN -> all outputs go to reset values asynchronously. After release, `active_count`=0 and `rd_ready`=1.
